// File: rtl/mac_csr_timeout_bridge.sv
// mac_csr_timeout_bridge
//   Avalon-MM bridge between the AFU MAC CSR master (s_*) and the 10G MAC CSR
//   slave (m_*). One transaction in flight; all MAC-side command signals are
//   registered. Each phase (command accept, read response) is bounded by
//   TIMEOUT_CYCLES. An aborted read returns ERR_DATA so MMIO never hangs.
//   Aborts are recorded in a sticky flag and a saturating counter.
// Ports:
//   clk, reset            clock, async active-high reset
//   s_address/s_writedata/s_write/s_read    upstream request
//   s_waitrequest/s_readdata/s_readdatavalid upstream response (registered)
//   m_address/m_writedata/m_write/m_read    MAC command (registered)
//   m_waitrequest/m_readdata/m_readdatavalid MAC response
//   err_clear             clears timeout_flag / timeout_count
//   timeout_flag          sticky abort indicator
//   timeout_count         saturating abort count
module mac_csr_timeout_bridge #(
   parameter int                ADDR_W         = 16,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF,
   parameter int                CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_address,
   input  logic [DATA_W-1:0] s_writedata,
   input  logic              s_write,
   input  logic              s_read,
   output logic              s_waitrequest,
   output logic [DATA_W-1:0] s_readdata,
   output logic              s_readdatavalid,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_write,
   output logic              m_read,
   input  logic              m_waitrequest,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_readdatavalid,
   input  logic              err_clear,
   output logic              timeout_flag,
   output logic [CNT_W-1:0]  timeout_count
);

   localparam int            PW     = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [PW-1:0] P_LAST = PW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {INIT, IDLE, CMD, RDWAIT} state_t;

   state_t        state, nstate;
   logic [PW-1:0] pcnt;
   logic          is_wr;
   logic          accept, cmd_done, rd_done, abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= INIT;
      else       state <= nstate;
   end

   // Completion is tested before the timeout so that a phase finishing on
   // its last allowed cycle is never aborted.
   always_comb begin
      nstate   = state;
      accept   = 1'b0;
      cmd_done = 1'b0;
      rd_done  = 1'b0;
      abort    = 1'b0;
      case (state)
         INIT: nstate = IDLE;
         IDLE: begin
            if (s_read || s_write) begin
               accept = 1'b1;
               nstate = CMD;
            end
         end
         CMD: begin
            if (!m_waitrequest) begin
               cmd_done = 1'b1;
               nstate   = is_wr ? IDLE : RDWAIT;
            end else if (pcnt == P_LAST) begin
               abort  = 1'b1;
               nstate = IDLE;
            end
         end
         RDWAIT: begin
            if (m_readdatavalid) begin
               rd_done = 1'b1;
               nstate  = IDLE;
            end else if (pcnt == P_LAST) begin
               abort  = 1'b1;
               nstate = IDLE;
            end
         end
         default: nstate = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_waitrequest   <= 1'b1;
         s_readdatavalid <= 1'b0;
         s_readdata      <= '0;
         m_address       <= '0;
         m_writedata     <= '0;
         m_write         <= 1'b0;
         m_read          <= 1'b0;
         is_wr           <= 1'b0;
         pcnt            <= '0;
         timeout_flag    <= 1'b0;
         timeout_count   <= '0;
      end else begin
         // Registered so it lines up with the state it describes.
         s_waitrequest   <= (nstate != IDLE);
         s_readdatavalid <= 1'b0;

         // Simultaneous read+write: the write wins, the read is dropped.
         if (accept) begin
            m_address   <= s_address;
            m_writedata <= s_writedata;
            is_wr       <= s_write;
            m_write     <= s_write;
            m_read      <= !s_write;
         end else if (cmd_done || abort) begin
            m_write <= 1'b0;
            m_read  <= 1'b0;
         end

         if (accept || cmd_done)
            pcnt <= '0;
         else if (state == CMD || state == RDWAIT)
            pcnt <= pcnt + PW'(1);

         if (rd_done) begin
            s_readdata      <= m_readdata;
            s_readdatavalid <= 1'b1;
         end else if (abort && !is_wr) begin
            s_readdata      <= ERR_DATA;
            s_readdatavalid <= 1'b1;
         end

         // An abort in the same cycle as err_clear counts as the first
         // abort after the clear.
         if (abort) begin
            timeout_flag <= 1'b1;
            if (err_clear)
               timeout_count <= CNT_W'(1);
            else if (!(&timeout_count))
               timeout_count <= timeout_count + CNT_W'(1);
         end else if (err_clear) begin
            timeout_flag  <= 1'b0;
            timeout_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mac_csr_timeout_bridge.sv
// tb_mac_csr_timeout_bridge
//   Self-checking bench for mac_csr_timeout_bridge built with a short timeout
//   (16) and a 2-bit abort counter. Expected read responses are queued when a
//   read is issued and popped when s_readdatavalid is seen.
module tb_mac_csr_timeout_bridge;
   localparam int          AW  = 16;
   localparam int          DW  = 32;
   localparam int          TO  = 16;
   localparam int          CW  = 2;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] s_address = '0;
   logic [DW-1:0] s_writedata = '0;
   logic          s_write = 1'b0, s_read = 1'b0;
   logic          s_waitrequest, s_readdatavalid;
   logic [DW-1:0] s_readdata;
   logic [AW-1:0] m_address;
   logic [DW-1:0] m_writedata;
   logic          m_write, m_read;
   logic          m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
   logic [DW-1:0] m_readdata = '0;
   logic          err_clear = 1'b0;
   logic          timeout_flag;
   logic [CW-1:0] timeout_count;

   int          vecs = 0;
   int          errs = 0;
   logic [31:0] exp_q[$];

   mac_csr_timeout_bridge #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .s_address(s_address), .s_writedata(s_writedata),
      .s_write(s_write), .s_read(s_read),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_writedata(m_writedata),
      .m_write(m_write), .m_read(m_read),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid),
      .err_clear(err_clear),
      .timeout_flag(timeout_flag), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one cycle once the bridge is ready; returns in
   // the first cycle after acceptance (cycle 1).
   task automatic issue(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [31:0] d);
      int n = 0;
      while (s_waitrequest !== 1'b0 && n < 64) begin
         tick();
         n++;
      end
      vecs++;
      if (s_waitrequest !== 1'b0) begin
         errs++;
         $display("FAIL accept_wait: s_waitrequest=%b required 0", s_waitrequest);
      end
      s_address = a; s_writedata = d; s_write = wr; s_read = rd;
      tick();
      s_write = 1'b0; s_read = 1'b0;
   endtask

   // MAC-side driver for cycles 1..ncyc: waitrequest high while c < wlow,
   // readdatavalid at rdv_at, err_clear at clr_at. Records what it observed.
   task automatic run(input int ncyc, input int wlow, input int rdv_at,
                      input logic [31:0] rdata, input int clr_at,
                      output int nrd, output int nwr, output int nval,
                      output int vcyc, output logic [31:0] vdata, output int lastcmd);
      nrd = 0; nwr = 0; nval = 0; vcyc = 0; vdata = '0; lastcmd = 0;
      for (int c = 1; c <= ncyc; c++) begin
         if (m_read === 1'b1) nrd++;
         if (m_write === 1'b1) nwr++;
         if (m_read === 1'b1 || m_write === 1'b1) lastcmd = c;
         if (s_readdatavalid === 1'b1) begin
            nval++; vcyc = c; vdata = s_readdata;
         end
         m_waitrequest   = (c < wlow);
         m_readdatavalid = (c == rdv_at);
         m_readdata      = (c == rdv_at) ? rdata : (32'h0BAD_0000 | 32'(c));
         err_clear       = (c == clr_at);
         tick();
      end
      m_waitrequest = 1'b0; m_readdatavalid = 1'b0; err_clear = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      vecs++;
      if ({s_waitrequest, s_readdatavalid, m_read, m_write, timeout_flag} !== 5'b10000) begin
         errs++;
         $display("FAIL reset_ctrl: got %b want 10000",
                  {s_waitrequest, s_readdatavalid, m_read, m_write, timeout_flag});
      end
      vecs++;
      if ({m_address, m_writedata, s_readdata, timeout_count} !== '0) begin
         errs++;
         $display("FAIL reset_data: addr=%h wd=%h rd=%h cnt=%0d want all zero",
                  m_address, m_writedata, s_readdata, timeout_count);
      end
      reset = 1'b0;
      vecs++;
      if (s_waitrequest !== 1'b1) begin
         errs++; $display("FAIL init_wait: got %b want 1", s_waitrequest);
      end
      tick();
      vecs++;
      if (s_waitrequest !== 1'b0) begin
         errs++; $display("FAIL idle_after_init: got %b want 0", s_waitrequest);
      end
   endtask

   task automatic test_write();
      issue(1'b1, 1'b0, 16'h0040, 32'h1234_5678);
      vecs++;
      if ({m_write, m_read, s_waitrequest} !== 3'b101) begin
         errs++; $display("FAIL wr_cmd: got %b want 101", {m_write, m_read, s_waitrequest});
      end
      vecs++;
      if (m_address !== 16'h0040 || m_writedata !== 32'h1234_5678) begin
         errs++; $display("FAIL wr_data: got %h/%h want 0040/12345678", m_address, m_writedata);
      end
      tick();
      vecs++;
      if ({m_write, s_waitrequest} !== 2'b00) begin
         errs++; $display("FAIL wr_done: got %b want 00", {m_write, s_waitrequest});
      end
   endtask

   task automatic test_back_to_back();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata;
      issue(1'b1, 1'b0, 16'h0010, 32'h0000_0A0A);
      tick();
      // Read and write together: the write is performed, the read vanishes.
      issue(1'b1, 1'b1, 16'h0044, 32'hAABB_CCDD);
      vecs++;
      if ({m_write, m_read} !== 2'b10 || m_address !== 16'h0044 || m_writedata !== 32'hAABB_CCDD) begin
         errs++;
         $display("FAIL rw_collide: wr=%b rd=%b addr=%h wd=%h want 1 0 0044 aabbccdd",
                  m_write, m_read, m_address, m_writedata);
      end
      run(8, 1, 0, 32'h0, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nval != 0 || nrd != 0) begin
         errs++; $display("FAIL rw_no_read: reads=%0d responses=%0d want 0 0", nrd, nval);
      end
   endtask

   task automatic test_read_stall();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata, e;
      issue(1'b0, 1'b1, 16'h0100, 32'h0);
      exp_q.push_back(32'hCAFE_0001);
      run(14, 6, 9, 32'hCAFE_0001, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nrd != 6 || nval != 1 || vcyc != 10) begin
         errs++;
         $display("FAIL rd_stall_timing: m_read=%0d resp=%0d at %0d want 6 1 10", nrd, nval, vcyc);
      end
      if (nval == 1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vecs++;
         if (vdata !== e) begin
            errs++; $display("FAIL rd_stall_data: got %h want %h", vdata, e);
         end
      end
      vecs++;
      if (timeout_flag !== 1'b0) begin
         errs++; $display("FAIL rd_stall_flag: got %b want 0", timeout_flag);
      end
   endtask

   task automatic test_cmd_timeout();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata, e;
      issue(1'b0, 1'b1, 16'h0200, 32'h0);
      exp_q.push_back(ERR);
      run(22, 1000, 0, 32'h0, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nrd != TO || lastcmd != TO || nval != 1 || vcyc != TO + 1) begin
         errs++;
         $display("FAIL cmd_to_timing: m_read=%0d last=%0d resp=%0d at %0d want %0d %0d 1 %0d",
                  nrd, lastcmd, nval, vcyc, TO, TO, TO + 1);
      end
      if (nval == 1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vecs++;
         if (vdata !== e) begin
            errs++; $display("FAIL cmd_to_data: got %h want %h", vdata, e);
         end
      end
      vecs++;
      if (timeout_flag !== 1'b1 || timeout_count !== 2'd1) begin
         errs++; $display("FAIL cmd_to_diag: flag=%b cnt=%0d want 1 1", timeout_flag, timeout_count);
      end
   endtask

   task automatic test_rd_timeout();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata, e;
      issue(1'b0, 1'b1, 16'h0300, 32'h0);
      exp_q.push_back(ERR);
      // Late MAC response at cycle 20 must be dropped.
      run(26, 1, 20, 32'h1111_2222, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nrd != 1 || nval != 1 || vcyc != TO + 2) begin
         errs++;
         $display("FAIL rd_to_timing: m_read=%0d resp=%0d at %0d want 1 1 %0d", nrd, nval, vcyc, TO + 2);
      end
      if (nval == 1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vecs++;
         if (vdata !== e) begin
            errs++; $display("FAIL rd_to_data: got %h want %h", vdata, e);
         end
      end
      vecs++;
      if (timeout_flag !== 1'b1 || timeout_count !== 2'd2) begin
         errs++; $display("FAIL rd_to_diag: flag=%b cnt=%0d want 1 2", timeout_flag, timeout_count);
      end
   endtask

   task automatic test_edge_complete();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata, e;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      vecs++;
      if (timeout_flag !== 1'b0 || timeout_count !== 2'd0) begin
         errs++; $display("FAIL clear: flag=%b cnt=%0d want 0 0", timeout_flag, timeout_count);
      end
      // Command completes in CMD cycle TO, response in RDWAIT cycle TO.
      issue(1'b0, 1'b1, 16'h0400, 32'h0);
      exp_q.push_back(32'hA5A5_0033);
      run(36, TO, 2 * TO, 32'hA5A5_0033, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nrd != TO || nval != 1 || vcyc != 2 * TO + 1) begin
         errs++;
         $display("FAIL edge_timing: m_read=%0d resp=%0d at %0d want %0d 1 %0d",
                  nrd, nval, vcyc, TO, 2 * TO + 1);
      end
      if (nval == 1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vecs++;
         if (vdata !== e) begin
            errs++; $display("FAIL edge_data: got %h want %h", vdata, e);
         end
      end
      vecs++;
      if (timeout_flag !== 1'b0 || timeout_count !== 2'd0) begin
         errs++; $display("FAIL edge_diag: flag=%b cnt=%0d want 0 0", timeout_flag, timeout_count);
      end
   endtask

   task automatic test_clear_vs_abort();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata;
      issue(1'b1, 1'b0, 16'h0500, 32'h5555_0000);
      run(20, 1000, 0, 32'h0, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nwr != TO || nval != 0 || timeout_count !== 2'd1) begin
         errs++;
         $display("FAIL wr_abort: m_write=%0d resp=%0d cnt=%0d want %0d 0 1", nwr, nval, timeout_count, TO);
      end
      issue(1'b1, 1'b0, 16'h0504, 32'h5555_0001);
      run(20, 1000, 0, 32'h0, TO, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (timeout_flag !== 1'b1 || timeout_count !== 2'd1) begin
         errs++; $display("FAIL clear_vs_abort: flag=%b cnt=%0d want 1 1", timeout_flag, timeout_count);
      end
   endtask

   task automatic test_saturate();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata;
      logic [CW-1:0] want;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         issue(1'b1, 1'b0, 16'h0600, 32'(i));
         run(18, 1000, 0, 32'h0, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
         want = (i > 3) ? 2'd3 : CW'(i);
         vecs++;
         if (timeout_count !== want) begin
            errs++; $display("FAIL saturate_%0d: got %0d want %0d", i, timeout_count, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      int nrd, nwr, nval, vcyc, lastcmd;
      logic [31:0] vdata;
      m_waitrequest = 1'b1;
      issue(1'b0, 1'b1, 16'h0700, 32'h0);
      tick(); tick();
      vecs++;
      if (m_read !== 1'b1) begin
         errs++; $display("FAIL mid_pre: m_read=%b want 1", m_read);
      end
      #2 reset = 1'b1;
      #1;
      vecs++;
      if ({m_read, s_waitrequest, s_readdatavalid, timeout_flag} !== 4'b0100 || timeout_count !== 2'd0) begin
         errs++;
         $display("FAIL mid_reset: rd/wait/val/flag=%b cnt=%0d want 0100 0",
                  {m_read, s_waitrequest, s_readdatavalid, timeout_flag}, timeout_count);
      end
      m_waitrequest = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      vecs++;
      if (s_waitrequest !== 1'b1) begin
         errs++; $display("FAIL mid_init: got %b want 1", s_waitrequest);
      end
      tick();
      vecs++;
      if (s_waitrequest !== 1'b0) begin
         errs++; $display("FAIL mid_idle: got %b want 0", s_waitrequest);
      end
      run(6, 1, 2, 32'h0000_0005, 0, nrd, nwr, nval, vcyc, vdata, lastcmd);
      vecs++;
      if (nval != 0 || nrd != 0 || exp_q.size() != 0) begin
         errs++;
         $display("FAIL mid_no_resp: resp=%0d m_read=%0d pending=%0d want 0 0 0", nval, nrd, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_read_stall();
      test_cmd_timeout();
      test_rd_timeout();
      test_edge_complete();
      test_clear_vs_abort();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
